sel8_func_unit: RTL and testbench
=================================

Name: sel8_func_unit

Overview:
- Parameterised 8-way function selector over two N-bit operands `a` and `b`.
- A 3-bit select {i1,i2,i3}, with i1 as MSB, picks one of eight logic/arithmetic results.
- The chosen result is registered on the clock edge.
- Used as a small datapath result mux/ALU slice feeding downstream registered logic.

Parameters:
- N, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- a  input  N  operand A.
- b  input  N  operand B.
- i1  input  1  select bit 2 (MSB).
- i2  input  1  select bit 1.
- i3  input  1  select bit 0 (LSB).
- y  output  N  registered selected result.
- co  output  1  registered carry/borrow flag.
- zero  output  1  registered flag, 1 when y == 0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Select value: sel = {i1,i2,i3}. The registered result is y = f(sel, a, b) as sampled at the rising edge of clk.
- sel 000: a & b.
- sel 001: a | b.
- sel 010: a ^ b.
- sel 011: ~(a & b), truncated to N bits.
- sel 100: a + b modulo 2^N; co = carry out of bit N-1.
- sel 101: a - b modulo 2^N; co = 1 when a < b unsigned (borrow).
- sel 110: a (pass-through).
- sel 111: b (pass-through).
- co is 0 for every sel other than 100 and 101.
- zero = (next y == 0), registered in the same cycle as y.
- Latency: exactly 1 cycle. Inputs sampled at edge k appear on y/co/zero after edge k.
- Output registers update every cycle; there is no enable and no hold state.
- Reset: when rst = 1 at a rising edge, y = 0, co = 0, zero = 1. Reset has priority over the computed result.
- Reset asserted mid-stream discards the in-flight result. The first result after rst deasserts reflects inputs sampled at the first edge with rst = 0.
- X/Z on select bits is undefined for synthesis. A simulation build may flag it with an assertion; RTL must not latch.
- All arithmetic is unsigned; there is no sign extension.
- Combinational path from inputs to register D only; there are no outputs combinational from inputs.

Decomposition:
- Shared package sel8_pkg:
  - 3-bit select typedef.
  - Named opcode constants SEL_AND=000, SEL_OR=001, SEL_XOR=010, SEL_NAND=011, SEL_ADD=100, SEL_SUB=101, SEL_PASS_A=110, SEL_PASS_B=111.
- One natural sub-module, sel8_func_core: purely combinational. Computes result and carry from sel, a, b.
- The top sel8_func_unit adds the zero detect and the output/flag registers with synchronous reset.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with a = 15, b = 6, sel = 100 -> y = 0, co = 0, zero = 1. One cycle after rst = 0: y = 21, co = 0.
- Sweep (N = 9, a = 15, b = 6, sel stepped 000..111 every cycle):
  - y = 6, 15, 9, 505, 21, 9, 15, 6, each one cycle after its select.
  - co = 0 throughout.
  - zero = 0 throughout.
- Add overflow (N = 9, a = 511, b = 1, sel = 100) -> y = 0, co = 1, zero = 1.
- Subtract borrow (N = 9, a = 6, b = 15, sel = 101) -> y = 503, co = 1, zero = 0. Then sel = 010 with a = b = 6 -> y = 0, zero = 1, co = 0.
- Mid-operation reset: assert rst for one cycle during the sweep at sel = 011 -> y = 0 that cycle. The next cycle resumes the correct value for the current sel.
- Width check (N = 1 and N = 64, random a/b, all 8 selects, ≥1000 vectors) -> y matches the reference model mod 2^N every cycle.

Source files
------------

// File: rtl/sel8_pkg.sv
// Shared select encoding for the 8-way function unit.
// The select is formed as {i1,i2,i3}, with i1 as the MSB.
package sel8_pkg;

    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_AND    = 3'b000;
    localparam sel_t SEL_OR     = 3'b001;
    localparam sel_t SEL_XOR    = 3'b010;
    localparam sel_t SEL_NAND   = 3'b011;
    localparam sel_t SEL_ADD    = 3'b100;
    localparam sel_t SEL_SUB    = 3'b101;
    localparam sel_t SEL_PASS_A = 3'b110;
    localparam sel_t SEL_PASS_B = 3'b111;

endpackage

// File: rtl/sel8_func_core.sv
// Combinational result/carry selection for the 8-way function unit.
// Add and subtract share an N+1 bit datapath so the top bit is the carry or borrow.
module sel8_func_core
    import sel8_pkg::*;
#(
    parameter int N = 8
) (
    input  sel_t         sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         carry
);

    logic [N:0] sum;
    logic [N:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Unsigned borrow shows up as bit N of the widened difference.
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (sel)
            SEL_AND:    result = a & b;
            SEL_OR:     result = a | b;
            SEL_XOR:    result = a ^ b;
            SEL_NAND:   result = ~(a & b);
            SEL_ADD: begin
                result = sum[N-1:0];
                carry  = sum[N];
            end
            SEL_SUB: begin
                result = diff[N-1:0];
                carry  = diff[N];
            end
            SEL_PASS_A: result = a;
            SEL_PASS_B: result = b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sel8_func_unit.sv
// Registered 8-way function selector: one-cycle latency result, carry and zero flag.
// Reset forces y=0, co=0, zero=1 and overrides the in-flight result.
module sel8_func_unit
    import sel8_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         i1,
    input  logic         i2,
    input  logic         i3,
    output logic [N-1:0] y,
    output logic         co,
    output logic         zero
);

    sel_t         sel_p0;
    logic [N-1:0] res_p0;
    logic         co_p0;
    logic [N-1:0] y_p1;
    logic         co_p1;
    logic         zero_p1;

    assign sel_p0 = {i1, i2, i3};

    sel8_func_core #(.N(N)) u_core (
        .sel    (sel_p0),
        .a      (a),
        .b      (b),
        .result (res_p0),
        .carry  (co_p0)
    );

    // p0 -> p1: output and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p1    <= '0;
            co_p1   <= 1'b0;
            zero_p1 <= 1'b1;
        end else begin
            y_p1    <= res_p0;
            co_p1   <= co_p0;
            zero_p1 <= (res_p0 == '0);
        end
    end

    assign y    = y_p1;
    assign co   = co_p1;
    assign zero = zero_p1;

endmodule

// File: tb/tb_sel8_func_unit.sv
// Scoreboard bench for sel8_func_unit at N = 9, 1 and 64 driven in lockstep.
// Directed N=9 expectations are literal values; the other widths use a reference model.
module tb_sel8_func_unit;

    typedef struct {
        logic [63:0] y;
        logic        co;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
    logic [8:0]  a9 = '0, b9 = '0, y9;
    logic [0:0]  a1 = '0, b1 = '0, y1;
    logic [63:0] a64 = '0, b64 = '0, y64;
    logic        co9, co1, co64, z9, z1, z64;

    exp_t q9[$], q1[$], q64[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sel8_func_unit #(.N(9)) dut9 (
        .clk(clk), .rst(rst), .a(a9), .b(b9), .i1(i1), .i2(i2), .i3(i3),
        .y(y9), .co(co9), .zero(z9)
    );
    sel8_func_unit #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .i1(i1), .i2(i2), .i3(i3),
        .y(y1), .co(co1), .zero(z1)
    );
    sel8_func_unit #(.N(64)) dut64 (
        .clk(clk), .rst(rst), .a(a64), .b(b64), .i1(i1), .i2(i2), .i3(i3),
        .y(y64), .co(co64), .zero(z64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int n, input logic r, input logic [2:0] s,
                                   input logic [63:0] av, input logic [63:0] bv);
        exp_t        e;
        logic [63:0] mask;
        logic [64:0] sum;
        logic [63:0] am, bm;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        am   = av & mask;
        bm   = bv & mask;
        e.y  = '0;
        e.co = 1'b0;
        if (!r) begin
            case (s)
                3'd0: e.y = am & bm;
                3'd1: e.y = am | bm;
                3'd2: e.y = am ^ bm;
                3'd3: e.y = ~(am & bm) & mask;
                3'd4: begin
                    sum  = {1'b0, am} + {1'b0, bm};
                    e.y  = sum[63:0] & mask;
                    e.co = sum[n];
                end
                3'd5: begin
                    e.y  = (am - bm) & mask;
                    e.co = (am < bm);
                end
                3'd6: e.y = am;
                default: e.y = bm;
            endcase
        end
        e.zero = (e.y == 64'd0);
        return e;
    endfunction

    // Drive one cycle, push expectations, then compare one edge later.
    task automatic cycle(input logic r, input logic [2:0] s, input logic [63:0] av,
                         input logic [63:0] bv, input exp_t e9, input string tag);
        exp_t g;
        @(negedge clk);
        rst = r;
        {i1, i2, i3} = s;
        a9 = av[8:0];  b9 = bv[8:0];
        a1 = av[0:0];  b1 = bv[0:0];
        a64 = av;      b64 = bv;
        q9.push_back(e9);
        q1.push_back(model(1, r, s, av, bv));
        q64.push_back(model(64, r, s, av, bv));
        @(posedge clk);
        #1;
        g = q9.pop_front();
        chk({tag, ".y9"}, {55'd0, y9}, g.y);
        chk({tag, ".co9"}, {63'd0, co9}, {63'd0, g.co});
        chk({tag, ".z9"}, {63'd0, z9}, {63'd0, g.zero});
        g = q1.pop_front();
        chk({tag, ".y1"}, {63'd0, y1}, g.y);
        chk({tag, ".co1"}, {63'd0, co1}, {63'd0, g.co});
        chk({tag, ".z1"}, {63'd0, z1}, {63'd0, g.zero});
        g = q64.pop_front();
        chk({tag, ".y64"}, y64, g.y);
        chk({tag, ".co64"}, {63'd0, co64}, {63'd0, g.co});
        chk({tag, ".z64"}, {63'd0, z64}, {63'd0, g.zero});
    endtask

    function automatic exp_t lit(input logic [63:0] y, input logic co, input logic z);
        exp_t e;
        e.y = y; e.co = co; e.zero = z;
        return e;
    endfunction

    logic [63:0] sweep_y [8] = '{64'd6, 64'd15, 64'd9, 64'd505, 64'd21, 64'd9, 64'd15, 64'd6};

    initial begin
        // Reset held two cycles with an add pending on the inputs
        cycle(1'b1, 3'b100, 64'd15, 64'd6, lit(64'd0, 1'b0, 1'b1), "rst0");
        cycle(1'b1, 3'b100, 64'd15, 64'd6, lit(64'd0, 1'b0, 1'b1), "rst1");
        cycle(1'b0, 3'b100, 64'd15, 64'd6, lit(64'd21, 1'b0, 1'b0), "rel");

        for (int s = 0; s < 8; s++)
            cycle(1'b0, 3'(s), 64'd15, 64'd6, lit(sweep_y[s], 1'b0, 1'b0), $sformatf("sweep%0d", s));

        cycle(1'b0, 3'b100, 64'd511, 64'd1, lit(64'd0, 1'b1, 1'b1), "addovf");
        cycle(1'b0, 3'b101, 64'd6, 64'd15, lit(64'd503, 1'b1, 1'b0), "subbor");
        cycle(1'b0, 3'b010, 64'd6, 64'd6, lit(64'd0, 1'b0, 1'b1), "xorzero");

        // Reset pulse in the middle of a sweep
        for (int s = 0; s < 3; s++)
            cycle(1'b0, 3'(s), 64'd15, 64'd6, lit(sweep_y[s], 1'b0, 1'b0), $sformatf("mid%0d", s));
        cycle(1'b1, 3'b011, 64'd15, 64'd6, lit(64'd0, 1'b0, 1'b1), "midrst");
        cycle(1'b0, 3'b011, 64'd15, 64'd6, lit(64'd505, 1'b0, 1'b0), "midresume");
        for (int s = 4; s < 8; s++)
            cycle(1'b0, 3'(s), 64'd15, 64'd6, lit(sweep_y[s], 1'b0, 1'b0), $sformatf("mid%0d", s));

        // Random vectors, all selects, all widths
        for (int k = 0; k < 1200; k++) begin
            logic [63:0] av, bv;
            logic [2:0]  s;
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            if (k % 16 == 0) bv = av;
            if (k % 16 == 1) av = '1;
            s  = 3'($urandom_range(0, 7));
            cycle(1'b0, s, av, bv, model(9, 1'b0, s, av, bv), $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
